hasti_xbar_n: RTL and testbench
===============================

Name: hasti_xbar_n

Overview:
- Parametrised single-master AHB-Lite (HASTI) bus fabric with NSLV slaves and an address map set by parameters.
- Decodes each address phase and broadcasts master control and write data to all slaves.
- Returns read data, response and ready from the slave that owns the current data phase, using a registered data-phase select.
- Includes an AHB-compliant two-cycle ERROR default slave and error-capture status registers for the system controller.

Parameters:
NSLV, 2, number of slave ports (1..16)
AW, 32, address width
DW, 32, data width
SLV_BASE, {32'h2000_0000, 32'h0000_0000}, packed NSLV*AW base addresses; entry i is slave i
SLV_MASK, {32'hFFFF_FC00, 32'hFFFF_FC00}, packed NSLV*AW decode masks; entry i is slave i
ERRCNT_W, 8, width of saturating error counter

Ports:
hclk  in  1  bus clock
hresetn  in  1  asynchronous active-low reset
m_haddr  in  AW  master address
m_hwrite  in  1  master write
m_hsize  in  3  transfer size
m_hburst  in  3  burst type
m_hprot  in  4  protection
m_htrans  in  2  IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
m_hmastlock  in  1  locked transfer
m_hwdata  in  DW  write data
m_hrdata  out  DW  read data to master
m_hready  out  1  transfer done / bus ready
m_hresp  out  1  0=OKAY 1=ERROR
s_hsel  out  NSLV  per-slave select, combinational from address phase
s_haddr, s_hwrite, s_hsize, s_hburst, s_hprot, s_htrans, s_hmastlock, s_hwdata  out  as master  broadcast copies of the master signals
s_hready  out  1  shared HREADY, equal to m_hready
s_hrdata  in  NSLV*DW  slave read data, slave i at [i*DW +: DW]
s_hreadyout  in  NSLV  slave ready outputs
s_hresp  in  NSLV  slave responses
err_addr  out  AW  address of the most recent unmapped active transfer
err_cnt  out  ERRCNT_W  count of unmapped active transfers, saturating

Behaviour:
- Decode, combinational:
  - match[i] = ((m_haddr & SLV_MASK[i]) == SLV_BASE[i]).
  - s_hsel is one-hot on the lowest matching index; on overlap the lower index wins.
  - No match selects the default slave.
- Broadcast: all s_* control and data outputs are direct copies of the master inputs, with no register.
- Data-phase select sel_r:
  - Holds a one-hot slave index or DEF.
  - Updates on the rising hclk only when m_hready=1: set to the slave index when any s_hsel is high, else DEF.
  - Holds while m_hready=0. Reset value is DEF.
- Return mux, combinational on sel_r:
  - Slave i selected: m_hrdata=s_hrdata[i], m_hresp=s_hresp[i], m_hready=s_hreadyout[i].
  - DEF selected: m_hrdata=0, with m_hresp and m_hready driven by the default-slave FSM.
- Default-slave FSM, states IDLE, ERR1, ERR2; reset state IDLE:
  - IDLE: hready=1, hresp=OKAY. If m_hready=1 and no slave is selected and m_htrans is NONSEQ or SEQ, go to ERR1.
  - ERR1: hready=0, hresp=ERROR. Go to ERR2 unconditionally.
  - ERR2: hready=1, hresp=ERROR. Sample the next address phase as IDLE does: a further unmapped active transfer goes to ERR1, otherwise go to IDLE.
  - IDLE or BUSY transfers to unmapped space get an OKAY zero-wait response and do not touch the status registers.
- Status registers:
  - On each IDLE/ERR2 to ERR1 transition, err_addr <= m_haddr.
  - On the same transition, err_cnt increments and saturates at all-ones.
  - Both reset to 0.
- Latency: zero added wait states; the fabric adds no pipeline register in the address or data path.
- Reset mid-transfer (hresetn low in any state): outputs take reset values immediately, i.e. m_hready=1, m_hresp=OKAY, m_hrdata=0, sel_r=DEF, FSM=IDLE.
- Master changing m_htrans to IDLE during ERR2 is legal; the FSM returns to IDLE.

Test Plan:
1. Reset, then NONSEQ read at 0x0000_0010 with slave0 giving 1 wait state and hrdata 0xDEAD_BEEF -> s_hsel=01; m_hready low for 1 cycle; m_hrdata=0xDEAD_BEEF; m_hresp=OKAY.
2. Back-to-back NONSEQ to 0x0000_0000 then 0x2000_0004, with slave1 stalling 2 cycles -> return mux switches to slave1 only after the slave0 data phase completes; slave1 data is returned; total time 1+3 cycles.
3. NONSEQ write to unmapped address 0x4000_0000 -> m_hready 0 then 1; m_hresp ERROR on both cycles; err_addr=0x4000_0000; err_cnt=1.
4. IDLE transfer to 0x4000_0000 -> OKAY, zero wait; err_cnt unchanged.
5. Overlapping map (both slaves with base 0, mask 0xFFFF_FC00); access 0x0000_0100 -> only s_hsel[0] asserted.
6. Assert hresetn low during ERR1 -> m_hready=1, m_hresp=OKAY and err_cnt=0 asynchronously. Separately, drive 300 unmapped NONSEQ transfers -> err_cnt saturates at 255.

Source files
------------

// File: rtl/hasti_xbar_n_if.sv
// Bus bundle for the single-master HASTI fabric: upstream master signals (m_*) and
// broadcast/returned slave-side signals (s_*). The fabric uses the slave modport.
interface hasti_xbar_n_if #(
  parameter int NSLV = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  logic [AW-1:0]      m_haddr;
  logic               m_hwrite;
  logic [2:0]         m_hsize;
  logic [2:0]         m_hburst;
  logic [3:0]         m_hprot;
  logic [1:0]         m_htrans;
  logic               m_hmastlock;
  logic [DW-1:0]      m_hwdata;
  logic [DW-1:0]      m_hrdata;
  logic               m_hready;
  logic               m_hresp;

  logic [NSLV-1:0]    s_hsel;
  logic [AW-1:0]      s_haddr;
  logic               s_hwrite;
  logic [2:0]         s_hsize;
  logic [2:0]         s_hburst;
  logic [3:0]         s_hprot;
  logic [1:0]         s_htrans;
  logic               s_hmastlock;
  logic [DW-1:0]      s_hwdata;
  logic               s_hready;
  logic [NSLV*DW-1:0] s_hrdata;
  logic [NSLV-1:0]    s_hreadyout;
  logic [NSLV-1:0]    s_hresp;

  // Fabric view: a slave to the bus master, a driver of the downstream slave ports.
  modport slave (
    input  m_haddr, m_hwrite, m_hsize, m_hburst, m_hprot, m_htrans, m_hmastlock, m_hwdata,
    output m_hrdata, m_hready, m_hresp,
    output s_hsel, s_haddr, s_hwrite, s_hsize, s_hburst, s_hprot, s_htrans, s_hmastlock,
    output s_hwdata, s_hready,
    input  s_hrdata, s_hreadyout, s_hresp
  );

  // Environment view: the bus master plus the attached slaves.
  modport master (
    output m_haddr, m_hwrite, m_hsize, m_hburst, m_hprot, m_htrans, m_hmastlock, m_hwdata,
    input  m_hrdata, m_hready, m_hresp,
    input  s_hsel, s_haddr, s_hwrite, s_hsize, s_hburst, s_hprot, s_htrans, s_hmastlock,
    input  s_hwdata, s_hready,
    output s_hrdata, s_hreadyout, s_hresp
  );
endinterface

// File: rtl/hasti_xbar_n.sv
// Single-master AHB-Lite fabric: address decode, broadcast, registered data-phase
// return mux, two-cycle ERROR default slave and error-capture status.
//
// state | meaning
// IDLE  | default slave idle, OKAY zero-wait
// ERR1  | first ERROR cycle, hready low
// ERR2  | second ERROR cycle, hready high, next address phase sampled
module hasti_xbar_n #(
  parameter int                  NSLV     = 2,
  parameter int                  AW       = 32,
  parameter int                  DW       = 32,
  parameter logic [NSLV*AW-1:0]  SLV_BASE = {32'h2000_0000, 32'h0000_0000},
  parameter logic [NSLV*AW-1:0]  SLV_MASK = {32'hFFFF_FC00, 32'hFFFF_FC00},
  parameter int                  ERRCNT_W = 8
) (
  input  logic                hclk,
  input  logic                hresetn,
  hasti_xbar_n_if.slave       bus,
  output logic [AW-1:0]       err_addr,
  output logic [ERRCNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [NSLV-1:0]       sel_q, sel_d;
  logic                  def_hready_q, def_hready_d;
  logic                  def_hresp_q, def_hresp_d;
  logic [AW-1:0]         err_addr_q, err_addr_d;
  logic [ERRCNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [NSLV-1:0]       match;
  logic [NSLV-1:0]       hsel;
  logic [DW-1:0]         ret_hrdata;
  logic                  ret_hready;
  logic                  ret_hresp;
  logic                  err_start;

  always_comb begin
    for (int i = 0; i < NSLV; i++) begin
      match[i] = ((bus.m_haddr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]);
    end
  end

  // Walk from the top down so the lowest matching index is the last one written.
  always_comb begin
    hsel = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (match[i]) begin
        hsel    = '0;
        hsel[i] = 1'b1;
      end
    end
  end

  assign bus.s_hsel      = hsel;
  assign bus.s_haddr     = bus.m_haddr;
  assign bus.s_hwrite    = bus.m_hwrite;
  assign bus.s_hsize     = bus.m_hsize;
  assign bus.s_hburst    = bus.m_hburst;
  assign bus.s_hprot     = bus.m_hprot;
  assign bus.s_htrans    = bus.m_htrans;
  assign bus.s_hmastlock = bus.m_hmastlock;
  assign bus.s_hwdata    = bus.m_hwdata;
  assign bus.s_hready    = ret_hready;

  // sel_q all-zero encodes the default slave.
  always_comb begin
    ret_hrdata = '0;
    ret_hresp  = 1'b0;
    ret_hready = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q[i]) begin
        ret_hrdata = ret_hrdata | bus.s_hrdata[i*DW +: DW];
        ret_hresp  = ret_hresp  | bus.s_hresp[i];
        ret_hready = ret_hready | bus.s_hreadyout[i];
      end
    end
    if (sel_q == '0) begin
      ret_hready = def_hready_q;
      ret_hresp  = def_hresp_q;
    end
  end

  assign bus.m_hrdata = ret_hrdata;
  assign bus.m_hready = ret_hready;
  assign bus.m_hresp  = ret_hresp;

  // Only NONSEQ/SEQ (htrans[1]=1) to unmapped space raise an error.
  assign err_start = ret_hready && (hsel == '0) && bus.m_htrans[1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (err_start) state_d = ERR1;
      ERR1:    state_d = ERR2;
      ERR2:    state_d = err_start ? ERR1 : IDLE;
      default: state_d = IDLE;
    endcase
    def_hready_d = (state_d != ERR1);
    def_hresp_d  = (state_d != IDLE);

    sel_d = ret_hready ? hsel : sel_q;

    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    if ((state_d == ERR1) && (state_q != ERR1)) begin
      err_addr_d = bus.m_haddr;
      if (~&err_cnt_q) err_cnt_d = err_cnt_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      def_hready_q <= 1'b1;
      def_hresp_q  <= 1'b0;
      err_addr_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      def_hready_q <= def_hready_d;
      def_hresp_q  <= def_hresp_d;
      err_addr_q   <= err_addr_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign err_addr = err_addr_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_hasti_xbar_n.sv
// Directed bench for hasti_xbar_n: decode, wait-state return, back-to-back switch,
// default-slave ERROR, overlap priority, async reset and counter saturation.
module tb_hasti_xbar_n;

  logic hclk;
  logic hresetn;
  int   checks;
  int   failures;

  logic [31:0] err_addr, ovl_err_addr;
  logic [7:0]  err_cnt, ovl_err_cnt;

  hasti_xbar_n_if #(.NSLV(2), .AW(32), .DW(32)) b ();
  hasti_xbar_n_if #(.NSLV(2), .AW(32), .DW(32)) ob ();

  hasti_xbar_n dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .bus      (b),
    .err_addr (err_addr),
    .err_cnt  (err_cnt)
  );

  hasti_xbar_n #(
    .SLV_BASE ({32'h0000_0000, 32'h0000_0000}),
    .SLV_MASK ({32'hFFFF_FC00, 32'hFFFF_FC00})
  ) u_ovl (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .bus      (ob),
    .err_addr (ovl_err_addr),
    .err_cnt  (ovl_err_cnt)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic next_cycle();
    @(posedge hclk);
    #1;
  endtask

  task automatic bus_idle();
    b.m_haddr = '0; b.m_hwrite = 1'b0; b.m_hsize = 3'd2; b.m_hburst = 3'd0;
    b.m_hprot = 4'h3; b.m_htrans = 2'd0; b.m_hmastlock = 1'b0; b.m_hwdata = '0;
    b.s_hrdata = '0; b.s_hreadyout = 2'b11; b.s_hresp = 2'b00;
    ob.m_haddr = '0; ob.m_hwrite = 1'b0; ob.m_hsize = 3'd2; ob.m_hburst = 3'd0;
    ob.m_hprot = 4'h3; ob.m_htrans = 2'd0; ob.m_hmastlock = 1'b0; ob.m_hwdata = '0;
    ob.s_hrdata = '0; ob.s_hreadyout = 2'b11; ob.s_hresp = 2'b00;
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    bus_idle();
    #12;
    checks++; if (b.m_hready !== 1'b1) begin failures++; $display("FAIL rst_hready got %b exp 1", b.m_hready); end
    checks++; if (b.m_hresp !== 1'b0) begin failures++; $display("FAIL rst_hresp got %b exp 0", b.m_hresp); end
    checks++; if (b.m_hrdata !== 32'h0) begin failures++; $display("FAIL rst_hrdata got %h exp 0", b.m_hrdata); end
    checks++; if (err_cnt !== 8'd0 || err_addr !== 32'h0) begin failures++; $display("FAIL rst_status got %h/%h exp 0/0", err_cnt, err_addr); end
    @(negedge hclk);
    hresetn = 1'b1;
    next_cycle();
  endtask

  task automatic test_wait_read();
    b.m_htrans = 2'd2; b.m_haddr = 32'h0000_0010; b.m_hwrite = 1'b0;
    @(negedge hclk);
    checks++; if (b.s_hsel !== 2'b01) begin failures++; $display("FAIL t1_hsel got %b exp 01", b.s_hsel); end
    checks++; if (b.s_haddr !== 32'h0000_0010) begin failures++; $display("FAIL t1_bcast_addr got %h exp 00000010", b.s_haddr); end
    checks++; if (b.m_hready !== 1'b1) begin failures++; $display("FAIL t1_addr_ready got %b exp 1", b.m_hready); end
    next_cycle();
    b.m_htrans = 2'd0; b.m_haddr = '0; b.s_hreadyout = 2'b10;
    @(negedge hclk);
    checks++; if (b.m_hready !== 1'b0) begin failures++; $display("FAIL t1_wait got %b exp 0", b.m_hready); end
    checks++; if (b.s_hready !== 1'b0) begin failures++; $display("FAIL t1_s_hready got %b exp 0", b.s_hready); end
    next_cycle();
    b.s_hreadyout = 2'b11; b.s_hrdata = {32'h0, 32'hDEAD_BEEF};
    @(negedge hclk);
    checks++; if (b.m_hready !== 1'b1) begin failures++; $display("FAIL t1_done got %b exp 1", b.m_hready); end
    checks++; if (b.m_hrdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL t1_rdata got %h exp deadbeef", b.m_hrdata); end
    checks++; if (b.m_hresp !== 1'b0) begin failures++; $display("FAIL t1_resp got %b exp 0", b.m_hresp); end
    next_cycle();
    b.s_hrdata = '0;
  endtask

  task automatic test_back_to_back();
    b.m_htrans = 2'd2; b.m_haddr = 32'h0000_0000;
    @(negedge hclk);
    checks++; if (b.s_hsel !== 2'b01) begin failures++; $display("FAIL t2_hsel0 got %b exp 01", b.s_hsel); end
    next_cycle();
    b.m_haddr = 32'h2000_0004; b.s_hreadyout = 2'b01;
    b.s_hrdata = {32'h2222_2222, 32'h1111_1111};
    @(negedge hclk);
    checks++; if (b.s_hsel !== 2'b10) begin failures++; $display("FAIL t2_hsel1 got %b exp 10", b.s_hsel); end
    checks++; if (b.m_hready !== 1'b1) begin failures++; $display("FAIL t2_s0_ready got %b exp 1", b.m_hready); end
    checks++; if (b.m_hrdata !== 32'h1111_1111) begin failures++; $display("FAIL t2_s0_rdata got %h exp 11111111", b.m_hrdata); end
    next_cycle();
    b.m_htrans = 2'd0; b.m_haddr = '0;
    @(negedge hclk);
    checks++; if (b.m_hready !== 1'b0) begin failures++; $display("FAIL t2_wait1 got %b exp 0", b.m_hready); end
    next_cycle();
    @(negedge hclk);
    checks++; if (b.m_hready !== 1'b0) begin failures++; $display("FAIL t2_wait2 got %b exp 0", b.m_hready); end
    next_cycle();
    b.s_hreadyout = 2'b11;
    @(negedge hclk);
    checks++; if (b.m_hready !== 1'b1) begin failures++; $display("FAIL t2_done got %b exp 1", b.m_hready); end
    checks++; if (b.m_hrdata !== 32'h2222_2222) begin failures++; $display("FAIL t2_s1_rdata got %h exp 22222222", b.m_hrdata); end
    next_cycle();
    b.s_hrdata = '0;
  endtask

  task automatic test_unmapped_write();
    b.m_htrans = 2'd2; b.m_haddr = 32'h4000_0000; b.m_hwrite = 1'b1;
    b.s_hrdata = {32'hAAAA_AAAA, 32'h5555_5555};
    @(negedge hclk);
    checks++; if (b.s_hsel !== 2'b00) begin failures++; $display("FAIL t3_hsel got %b exp 00", b.s_hsel); end
    checks++; if (b.m_hready !== 1'b1) begin failures++; $display("FAIL t3_addr_ready got %b exp 1", b.m_hready); end
    next_cycle();
    b.m_htrans = 2'd0; b.m_haddr = '0; b.m_hwrite = 1'b0;
    @(negedge hclk);
    checks++; if (b.m_hready !== 1'b0 || b.m_hresp !== 1'b1) begin failures++; $display("FAIL t3_err1 got rdy=%b resp=%b exp rdy=0 resp=1", b.m_hready, b.m_hresp); end
    checks++; if (b.m_hrdata !== 32'h0) begin failures++; $display("FAIL t3_rdata got %h exp 0", b.m_hrdata); end
    checks++; if (err_addr !== 32'h4000_0000) begin failures++; $display("FAIL t3_err_addr got %h exp 40000000", err_addr); end
    checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL t3_err_cnt got %0d exp 1", err_cnt); end
    next_cycle();
    @(negedge hclk);
    checks++; if (b.m_hready !== 1'b1 || b.m_hresp !== 1'b1) begin failures++; $display("FAIL t3_err2 got rdy=%b resp=%b exp rdy=1 resp=1", b.m_hready, b.m_hresp); end
    next_cycle();
    @(negedge hclk);
    checks++; if (b.m_hready !== 1'b1 || b.m_hresp !== 1'b0) begin failures++; $display("FAIL t3_back_idle got rdy=%b resp=%b exp rdy=1 resp=0", b.m_hready, b.m_hresp); end
    next_cycle();
    b.s_hrdata = '0;
  endtask

  task automatic test_idle_unmapped();
    b.m_htrans = 2'd0; b.m_haddr = 32'h4000_0000;
    next_cycle();
    b.m_htrans = 2'd1; b.m_haddr = 32'h4800_0000;
    @(negedge hclk);
    checks++; if (b.m_hready !== 1'b1 || b.m_hresp !== 1'b0) begin failures++; $display("FAIL t4_idle got rdy=%b resp=%b exp rdy=1 resp=0", b.m_hready, b.m_hresp); end
    next_cycle();
    b.m_htrans = 2'd0; b.m_haddr = '0;
    @(negedge hclk);
    checks++; if (b.m_hready !== 1'b1 || b.m_hresp !== 1'b0) begin failures++; $display("FAIL t4_busy got rdy=%b resp=%b exp rdy=1 resp=0", b.m_hready, b.m_hresp); end
    checks++; if (err_cnt !== 8'd1 || err_addr !== 32'h4000_0000) begin failures++; $display("FAIL t4_status got cnt=%0d addr=%h exp cnt=1 addr=40000000", err_cnt, err_addr); end
    next_cycle();
  endtask

  task automatic test_overlap();
    ob.m_htrans = 2'd2; ob.m_haddr = 32'h0000_0100;
    @(negedge hclk);
    checks++; if (ob.s_hsel !== 2'b01) begin failures++; $display("FAIL t5_overlap_hsel got %b exp 01", ob.s_hsel); end
    next_cycle();
    ob.m_htrans = 2'd0; ob.m_haddr = '0;
    next_cycle();
  endtask

  task automatic test_reset_err1();
    b.m_htrans = 2'd2; b.m_haddr = 32'h5000_0000;
    next_cycle();
    b.m_htrans = 2'd0; b.m_haddr = '0;
    @(negedge hclk);
    checks++; if (b.m_hready !== 1'b0 || err_cnt !== 8'd2) begin failures++; $display("FAIL t6_pre got rdy=%b cnt=%0d exp rdy=0 cnt=2", b.m_hready, err_cnt); end
    #1 hresetn = 1'b0;
    #1;
    checks++; if (b.m_hready !== 1'b1 || b.m_hresp !== 1'b0) begin failures++; $display("FAIL t6_async got rdy=%b resp=%b exp rdy=1 resp=0", b.m_hready, b.m_hresp); end
    checks++; if (err_cnt !== 8'd0 || err_addr !== 32'h0) begin failures++; $display("FAIL t6_status got cnt=%0d addr=%h exp 0/0", err_cnt, err_addr); end
    next_cycle();
    hresetn = 1'b1;
    @(negedge hclk);
    checks++; if (b.m_hready !== 1'b1 || b.m_hresp !== 1'b0) begin failures++; $display("FAIL t6_after got rdy=%b resp=%b exp rdy=1 resp=0", b.m_hready, b.m_hresp); end
    next_cycle();
  endtask

  task automatic test_saturate();
    b.m_htrans = 2'd2; b.m_haddr = 32'h6000_0000;
    // Errors land on every second edge: after edge 2k-1 the count is k.
    repeat (507) next_cycle();
    checks++; if (err_cnt !== 8'd254) begin failures++; $display("FAIL t6_cnt254 got %0d exp 254", err_cnt); end
    repeat (92) next_cycle();
    checks++; if (err_cnt !== 8'd255) begin failures++; $display("FAIL t6_sat got %0d exp 255", err_cnt); end
    checks++; if (err_addr !== 32'h6000_0000) begin failures++; $display("FAIL t6_sat_addr got %h exp 60000000", err_addr); end
    b.m_htrans = 2'd0; b.m_haddr = '0;
    repeat (2) next_cycle();
    @(negedge hclk);
    checks++; if (b.m_hresp !== 1'b0 || err_cnt !== 8'd255) begin failures++; $display("FAIL t6_sat_idle got resp=%b cnt=%0d exp resp=0 cnt=255", b.m_hresp, err_cnt); end
    next_cycle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    hresetn  = 1'b0;
    test_reset();
    test_wait_read();
    test_back_to_back();
    test_unmapped_write();
    test_idle_unmapped();
    test_overlap();
    test_reset_err1();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
